dmem_arbiter: RTL

//  Shares the single-port synchronous data memory between the pipeline MEM stage (port C) and a

---
 rtl/dmem_arbiter_pkg.sv | 20 ++
 rtl/dmem_arbiter_if.sv | 60 ++++++
 rtl/dmem_starve_cnt.sv | 46 ++++
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_pkg
// Description : Shared types and constants for the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

    // Default number of words in the shared data memory
    localparam int DMEM_DEPTH = 256;

    // Which port owns the read data returning from memory this cycle
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } arb_owner_e;

endpackage : dmem_arbiter_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Bundle of the core (MEM stage), debug/loader and memory-side
//               signals around the data-memory arbiter. The slave modport is
//               the arbiter's view; the master modport is its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 8
);
    // Core (MEM stage) port
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_stall;
    logic              core_rvalid;
    logic [DATA_W-1:0] core_rdata;

    // Debug / loader port
    logic              dbg_halt;
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic              oob_err;

    // Single-port synchronous memory side
    logic              mem_en;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_stall, core_rvalid, core_rdata,
        input  dbg_halt, dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata, oob_err,
        output mem_en, mem_we, mem_idx, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_stall, core_rvalid, core_rdata,
        output dbg_halt, dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata, oob_err,
        input  mem_en, mem_we, mem_idx, mem_wdata,
        output mem_rdata
    );

endinterface : dmem_arbiter_if
`default_nettype wire

// File: rtl/dmem_starve_cnt.sv
`default_nettype none
// ============================================================================
// Module      : dmem_starve_cnt
// Description : Saturating counter of consecutive cycles the debug port has
//               been kept waiting. sat_o flags that the limit was reached.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_starve_cnt #(
    parameter int LIMIT = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic inc_i,
    input  wire logic clr_i,
    output logic      sat_o
);

    localparam int                 c_CNT_W = $clog2(LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(LIMIT);

    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;

    // Clear has priority over increment; hold once the limit is reached
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != c_LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == c_LIMIT);

endmodule : dmem_starve_cnt
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares one single-port synchronous data memory between the
//               pipeline MEM stage (core) and a debug/loader port. The core
//               wins by default; the debug port is guaranteed a slot after
//               STARVE_LIMIT consecutive losing cycles, and owns the memory
//               outright while dbg_halt is high.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int DEPTH        = DMEM_DEPTH,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    dmem_arbiter_if.slave   bus
);

    localparam int                  IDX_W         = $clog2(DEPTH);
    localparam logic [ADDR_W-3:0]   c_DEPTH_WORDS = (ADDR_W - 2)'(DEPTH);

    logic              w_dbg_sat;
    logic              w_grant_c;
    logic              w_grant_d;
    logic              w_granted;
    logic              w_sel_we;
    logic              w_sel_oob;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_core_hit;
    logic              w_dbg_hit;
    logic              w_unused_addr;

    arb_owner_e        owner_q;
    arb_owner_e        owner_d;
    logic              oob_err_q;
    logic [DATA_W-1:0] core_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;

    // Starvation tracking: counts cycles debug waits, cleared once served or idle
    dmem_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (bus.dbg_req && !w_grant_d),
        .clr_i (w_grant_d || !bus.dbg_req),
        .sat_o (w_dbg_sat)
    );

    // Grant decision: halt hands memory to debug; otherwise core unless debug is starved
    always_comb begin
        w_grant_c = 1'b0;
        w_grant_d = 1'b0;
        if (rst_n) begin
            if (bus.dbg_halt) begin
                w_grant_d = bus.dbg_req;
            end else if (bus.core_req && !(bus.dbg_req && w_dbg_sat)) begin
                w_grant_c = 1'b1;
            end else begin
                w_grant_d = bus.dbg_req;
            end
        end
    end

    // Route the winning port's request fields toward memory
    always_comb begin
        if (w_grant_c) begin
            w_sel_we    = bus.core_we;
            w_sel_addr  = bus.core_addr;
            w_sel_wdata = bus.core_wdata;
        end else begin
            w_sel_we    = bus.dbg_we;
            w_sel_addr  = bus.dbg_addr;
            w_sel_wdata = bus.dbg_wdata;
        end
    end

    // Byte offset is ignored: accesses are whole words only
    assign w_unused_addr = ^w_sel_addr[1:0];

    assign w_granted  = w_grant_c || w_grant_d;
    assign w_sel_oob  = (w_sel_addr[ADDR_W-1:2] >= c_DEPTH_WORDS);

    assign bus.mem_en     = w_granted && !w_sel_oob;
    assign bus.mem_we     = bus.mem_en && w_sel_we;
    assign bus.mem_idx    = w_sel_addr[IDX_W+1:2];
    assign bus.mem_wdata  = w_sel_wdata;

    assign bus.core_stall = rst_n && bus.core_req && !w_grant_c;
    assign bus.dbg_gnt    = w_grant_d;

    // Next owner of the read data: whoever was granted a read this cycle
    always_comb begin
        owner_d = OWN_NONE;
        if (w_granted && !w_sel_we) begin
            owner_d = w_grant_c ? OWN_CORE : OWN_DBG;
        end
    end

    // Out-of-range reads complete normally but deliver zero instead of memory data.
    // Gating with rst_n drops a pending response when reset lands mid-read.
    assign w_rd_data   = oob_err_q ? '0 : bus.mem_rdata;
    assign w_core_hit  = rst_n && (owner_q == OWN_CORE);
    assign w_dbg_hit   = rst_n && (owner_q == OWN_DBG);

    assign bus.core_rvalid = w_core_hit;
    assign bus.dbg_rvalid  = w_dbg_hit;
    assign bus.core_rdata  = w_core_hit ? w_rd_data : core_rdata_q;
    assign bus.dbg_rdata   = w_dbg_hit  ? w_rd_data : dbg_rdata_q;
    assign bus.oob_err     = oob_err_q;

    // Owner FSM plus held read data and the out-of-range pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q      <= OWN_NONE;
            oob_err_q    <= 1'b0;
            core_rdata_q <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            owner_q      <= owner_d;
            oob_err_q    <= w_granted && w_sel_oob;
            core_rdata_q <= bus.core_rdata;
            dbg_rdata_q  <= bus.dbg_rdata;
        end
    end

endmodule : dmem_arbiter
`default_nettype wire
